// File: rtl/multicycle_mem.sv
//==============================================================================
// Module      : multicycle_mem
// Description : Multi-cycle data-memory responder. Accepts one read or write
//               per transaction, models a fixed access latency and drives
//               mem_ready so the CPU pipeline can freeze while an access is
//               outstanding. Stores 2^DEPTH_W 16-bit words at even byte
//               addresses.
//               Optional build macro: MEM_FAST_WRITE_EN (posted writes commit
//               in the issue cycle without stalling the pipeline).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_mem #(
    parameter int LATENCY = 4,   // total stall cycles per access, 2..15
    parameter int DEPTH_W = 12   // word-index bits
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        mem_ready,
    output logic        data_valid,
    output logic        busy
);

    localparam int         c_WORDS    = 1 << DEPTH_W;
    // The counter is loaded with LATENCY-2: the issue cycle and the DONE
    // transition edge account for the remaining two stall cycles.
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_wr;
    logic [DEPTH_W-1:0]   r_idx;
    logic [15:0]          r_wdata;
    logic [15:0]          r_mem [c_WORDS];

    logic [DEPTH_W-1:0]   w_idx;
    logic                 w_issue;
    logic                 w_mem_we;
    logic [DEPTH_W-1:0]   w_mem_idx;
    logic [15:0]          w_mem_wdata;
    logic                 w_unused_addr;

    // Byte address to word index; addr[0] and the upper bits are don't-care.
    assign w_idx         = addr[DEPTH_W:1];
    assign w_unused_addr = ^addr;

`ifdef MEM_FAST_WRITE_EN
    // Only reads enter the multi-cycle path; writes are posted.
    assign w_issue = (r_state == ST_IDLE) && enable && !wr;
`else
    assign w_issue = (r_state == ST_IDLE) && enable;
`endif

    // Storage write port: latched write on the edge into DONE, or a posted
    // write straight from the request inputs when fast writes are enabled.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_idx;
        w_mem_wdata = r_wdata;
        if ((r_state == ST_BUSY) && (r_cnt == 4'd0) && r_wr) begin
            w_mem_we = 1'b1;
        end
`ifdef MEM_FAST_WRITE_EN
        else if ((r_state == ST_IDLE) && enable && wr) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = w_idx;
            w_mem_wdata = data_in;
        end
`endif
    end

    // Storage array; not cleared by reset, but a reset edge blocks any commit
    // so an interrupted write is discarded.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Transaction FSM with registered data_out, data_valid and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 16'd0;
            data_out   <= 16'd0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    data_valid <= 1'b0;
                    if (w_issue) begin
                        r_wr    <= wr;
                        r_idx   <= w_idx;
                        r_wdata <= data_in;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= ST_BUSY;
                        busy    <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= ST_DONE;
                        data_valid <= !r_wr;
                        if (!r_wr) begin
                            data_out <= r_mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Any enable seen here belongs to the completing access.
                    r_state    <= ST_IDLE;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline handshake: stall from the issue cycle until DONE.
    always_comb begin
        mem_ready = 1'b0;
        case (r_state)
`ifdef MEM_FAST_WRITE_EN
            ST_IDLE: mem_ready = !(enable && !wr);
`else
            ST_IDLE: mem_ready = !enable;
`endif
            ST_BUSY: mem_ready = 1'b0;
            ST_DONE: mem_ready = 1'b1;
            default: mem_ready = 1'b0;
        endcase
    end

endmodule

`default_nettype wire
